// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port identifiers and the default memory latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MEM_LAT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that times the fixed memory latency. The flag
// cnt_one marks the last BUSY cycle, when memory read data is valid.
module mem_arb_lat_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             cnt_one
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load takes precedence; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between the instruction
// fetch port and the data (LW/SW) port. One access at a time: IDLE grants,
// BUSY times the memory latency, DONE pulses the granted port's done.
// Optional macro MEM_ARB_RR_EN: round-robin between the ports on simultaneous
// requests; without it the data port always wins a tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              en_q, en_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              win_port;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_one;
`ifdef MEM_ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  mem_arb_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .cnt_one  (cnt_one)
  );

  // Pick the winner among the current requesters; a lone requester always wins.
  always_comb begin
    win_port = PORT_I;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) begin
      win_port = ~last_grant_q;
    end else if (d_req) begin
      win_port = PORT_D;
    end
`else
    if (d_req) begin
      win_port = PORT_D;
    end
`endif
  end

  // Next-state logic plus grant/datapath register updates.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    en_d      = 1'b0;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = BUSY;
          grant_d  = win_port;
          en_d     = 1'b1;
          cnt_load = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_grant_d = win_port;
`endif
          if (win_port == PORT_D) begin
            addr_d  = d_addr;
            wr_d    = d_wr;
            wdata_d = d_wdata;
          end else begin
            // Fetches are always reads with a quiet write-data bus.
            addr_d  = i_addr;
            wr_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_one) begin
          state_d = DONE;
          if (!wr_q) begin
            if (grant_q == PORT_D) begin
              d_rdata_d = mem_data_out;
            end else begin
              i_rdata_d = mem_data_out;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, memory-bus and read-data registers; all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q   <= PORT_I;
      en_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      grant_q   <= grant_d;
      en_q      <= en_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remembers the last granted port; starts at data so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PORT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem_enable  = en_q;
  assign mem_wr      = wr_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q != IDLE);
  assign i_done      = (state_q == DONE) && (grant_q == PORT_I);
  assign d_done      = (state_q == DONE) && (grant_q == PORT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// continuous-request and mid-access-reset sequences, then randomized
// transactions scored against a cycle-arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          i_done, d_done, mem_enable, mem_wr, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Memory device: data is presented only in the cycle MEM_LAT-1 after the enable cycle.
  logic [DW-1:0] tbmem [0:1023];
  logic [9:0]    m_addr = '0;
  int            m_age = 0;
  logic          mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 1024; k++) tbmem[k] <= 16'hC000 | 16'(k);
      tbmem[16] <= 16'hA123;
      mem_init_done <= 1'b1;
    end else if (!rst_n) begin
      m_age <= 0;
    end else if (mem_enable) begin
      m_addr <= mem_addr[9:0];
      m_age  <= 1;
      if (mem_wr) tbmem[mem_addr[9:0]] <= mem_data_in;
    end else if (m_age != 0 && m_age < 15) begin
      m_age <= m_age + 1;
    end
  end
  assign mem_data_out = (m_age == LAT - 1) ? tbmem[m_addr] : 16'h5A5A;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_enable"}, int'(mem_enable), 0);
    chk({tag, " mem_wr"}, int'(mem_wr), 0);
    chk({tag, " mem_addr"}, int'(mem_addr), 0);
    chk({tag, " mem_data_in"}, int'(mem_data_in), 0);
    chk({tag, " i_done"}, int'(i_done), 0);
    chk({tag, " d_done"}, int'(d_done), 0);
    chk({tag, " i_rdata"}, int'(i_rdata), 0);
    chk({tag, " d_rdata"}, int'(d_rdata), 0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  // Reference model state: memory contents, last read data per port, last grant.
  logic [DW-1:0] model_mem [0:1023];
  logic [DW-1:0] m_last_i, m_last_d;
  bit            m_lg_d;

  task automatic model_access(input bit is_d, input logic [15:0] ia, input logic dw,
                              input logic [15:0] da, input logic [15:0] dwd);
    if (!is_d) m_last_i = model_mem[ia[9:0]];
    else if (dw) model_mem[da[9:0]] = dwd;
    else m_last_d = model_mem[da[9:0]];
    m_lg_d = is_d;
  endtask

  // Predict done cycles and first memory access from the arbitration rules.
  task automatic model_case(input int si, input logic [15:0] ia, input int sd, input logic dw,
                            input logic [15:0] da, input logic [15:0] dwd,
                            output int e_idc, output int e_ddc, output int e_en,
                            output logic e_fw, output logic [15:0] e_fa, output logic [15:0] e_fd);
    bit both, first_d;
    int g1, d1, s2, g2, d2;
    both = (si >= 0) && (sd >= 0);
    if (sd < 0) first_d = 1'b0;
    else if (si < 0) first_d = 1'b1;
    else if (si == sd) first_d = RR ? !m_lg_d : 1'b1;
    else first_d = (sd < si);
    g1 = first_d ? sd : si;
    d1 = g1 + LAT + 1;
    s2 = first_d ? si : sd;
    g2 = (s2 > d1 + 1) ? s2 : d1 + 1;
    d2 = g2 + LAT + 1;
    e_idc = first_d ? (both ? d2 : -1) : d1;
    e_ddc = first_d ? d1 : (both ? d2 : -1);
    e_en  = both ? 2 : 1;
    e_fw  = first_d ? dw : 1'b0;
    e_fa  = first_d ? da : ia;
    e_fd  = first_d ? dwd : 16'h0000;
    model_access(first_d, ia, dw, da, dwd);
    if (both) model_access(!first_d, ia, dw, da, dwd);
  endtask

  // Drive one case (start cycles relative to cycle 0) and observe the DUT.
  task automatic run_case(input int si, input logic [15:0] ia, input int sd, input logic dw,
                          input logic [15:0] da, input logic [15:0] dwd,
                          output int idc, output int ddc, output int en_cnt,
                          output logic fw, output logic [15:0] fa, output logic [15:0] fd,
                          output int viol);
    bit i_fin, d_fin, i_drop, d_drop;
    int prev_done;
    idc = -1; ddc = -1; en_cnt = 0; viol = 0; fw = 1'b0; fa = '0; fd = '0;
    i_fin = (si < 0); d_fin = (sd < 0); i_drop = 0; d_drop = 0; prev_done = -10;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      if (i_drop) begin i_req = 1'b0; i_addr = 16'($urandom); i_drop = 0; end
      if (d_drop) begin
        d_req = 1'b0; d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = 1'($urandom);
        d_drop = 0;
      end
      if (c == si) begin i_req = 1'b1; i_addr = ia; end
      if (c == sd) begin d_req = 1'b1; d_wr = dw; d_addr = da; d_wdata = dwd; end
      @(negedge clk);
      if (mem_enable) begin
        if (en_cnt == 0) begin fw = mem_wr; fa = mem_addr; fd = mem_data_in; end
        en_cnt++;
      end
      if (i_done && d_done) viol++;
      if ((i_done || d_done) && (prev_done == c - 1 || !busy)) viol++;
      if (i_done || d_done) prev_done = c;
      if (i_done) begin if (idc < 0) idc = c; else viol++; i_drop = 1; i_fin = 1; end
      if (d_done) begin if (ddc < 0) ddc = c; else viol++; d_drop = 1; d_fin = 1; end
      if (i_fin && d_fin) break;
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
  endtask

  typedef struct {
    int si; logic [15:0] ia;
    int sd; logic dw; logic [15:0] da; logic [15:0] dwd;
    int eidc; int eddc;
    logic [15:0] eird; logic [15:0] edrd;
    logic efw; logic [15:0] efa; logic [15:0] efd;
  } vec_t;

  vec_t vecs[6];
  int   idc, ddc, en_cnt, viol, e_idc, e_ddc, e_en;
  logic fw, e_fw;
  logic [15:0] fa, fd, e_fa, e_fd;
  int   dc[3];
  int   ndone, prev;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 16'h0010, -1, 1'b0, 16'h0000, 16'h0000, 5, -1, 16'hA123, 16'h0000, 1'b0, 16'h0010, 16'h0000};
    vecs[1] = '{-1, 16'h0000, 0, 1'b1, 16'h0200, 16'hBEEF, -1, 5, 16'hA123, 16'h0000, 1'b1, 16'h0200, 16'hBEEF};
`ifdef MEM_ARB_RR_EN
    vecs[2] = '{0, 16'h0004, 0, 1'b0, 16'h0100, 16'h0000, 5, 11, 16'hC004, 16'hC100, 1'b0, 16'h0004, 16'h0000};
`else
    vecs[2] = '{0, 16'h0004, 0, 1'b0, 16'h0100, 16'h0000, 11, 5, 16'hC004, 16'hC100, 1'b0, 16'h0100, 16'h0000};
`endif
    vecs[3] = '{-1, 16'h0000, 0, 1'b0, 16'h0200, 16'h0000, -1, 5, 16'hC004, 16'hBEEF, 1'b0, 16'h0200, 16'h0000};
    vecs[4] = '{0, 16'h0010, 2, 1'b0, 16'h0004, 16'h0000, 5, 11, 16'hA123, 16'hC004, 1'b0, 16'h0010, 16'h0000};
`ifdef MEM_ARB_RR_EN
    vecs[5] = '{0, 16'h0200, 0, 1'b1, 16'h0200, 16'h1111, 5, 11, 16'hBEEF, 16'hC004, 1'b0, 16'h0200, 16'h0000};
`else
    vecs[5] = '{0, 16'h0200, 0, 1'b1, 16'h0200, 16'h1111, 11, 5, 16'h1111, 16'hC004, 1'b1, 16'h0200, 16'h1111};
`endif

    for (int k = 0; k < 1024; k++) model_mem[k] = 16'hC000 | 16'(k);
    model_mem[16] = 16'hA123;
    m_last_i = '0; m_last_d = '0; m_lg_d = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table
    for (int k = 0; k < 6; k++) begin
      run_case(vecs[k].si, vecs[k].ia, vecs[k].sd, vecs[k].dw, vecs[k].da, vecs[k].dwd,
               idc, ddc, en_cnt, fw, fa, fd, viol);
      model_case(vecs[k].si, vecs[k].ia, vecs[k].sd, vecs[k].dw, vecs[k].da, vecs[k].dwd,
                 e_idc, e_ddc, e_en, e_fw, e_fa, e_fd);
      chk($sformatf("vec%0d i_done_cycle", k), idc, vecs[k].eidc);
      chk($sformatf("vec%0d d_done_cycle", k), ddc, vecs[k].eddc);
      chk($sformatf("vec%0d i_rdata", k), int'(i_rdata), int'(vecs[k].eird));
      chk($sformatf("vec%0d d_rdata", k), int'(d_rdata), int'(vecs[k].edrd));
      chk($sformatf("vec%0d mem_enable_count", k), en_cnt, (vecs[k].si >= 0 ? 1 : 0) + (vecs[k].sd >= 0 ? 1 : 0));
      chk($sformatf("vec%0d mem_wr", k), int'(fw), int'(vecs[k].efw));
      chk($sformatf("vec%0d mem_addr", k), int'(fa), int'(vecs[k].efa));
      chk($sformatf("vec%0d mem_data_in", k), int'(fd), int'(vecs[k].efd));
      chk($sformatf("vec%0d done_protocol", k), viol, 0);
    end

    // Continuous instruction requests: three accesses back to back
    ndone = 0; prev = -10; viol = 0;
    for (int c = 0; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin i_req = 1'b1; i_addr = 16'h0010; end
      if (c == 18) i_req = 1'b0;
      @(negedge clk);
      if (d_done) viol++;
      if (i_done) begin
        if (prev == c - 1) viol++;
        if (ndone < 3) dc[ndone] = c;
        ndone++;
        prev = c;
      end
    end
    m_last_i = model_mem[16]; m_lg_d = 1'b0;
    chk("cont done_count", ndone, 3);
    chk("cont done_1", dc[0], 5);
    chk("cont done_2", dc[1], 11);
    chk("cont done_3", dc[2], 17);
    chk("cont protocol", viol, 0);
    chk("cont i_rdata", int'(i_rdata), 16'hA123);

    // Reset in the middle of a read abandons it without a done
    ndone = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin i_req = 1'b1; i_addr = 16'h0004; end
      if (c == 3) rst_n = 1'b0;
      if (c == 4) begin rst_n = 1'b1; i_req = 1'b0; end
      @(negedge clk);
      if (c == 4) chk_all_zero("midreset");
      if (i_done || d_done) ndone++;
    end
    chk("midreset no_done", ndone, 0);
    m_last_i = '0; m_last_d = '0; m_lg_d = 1'b1;

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      int si, sd;
      logic dw;
      logic [15:0] ia, da, dwd;
      si  = int'($urandom_range(0, 4)) - 1;
      sd  = int'($urandom_range(0, 4)) - 1;
      if (si < 0 && sd < 0) si = 0;
      ia  = 16'($urandom_range(0, 1023));
      da  = ($urandom_range(0, 3) == 0) ? ia : 16'($urandom_range(0, 1023));
      dw  = 1'($urandom);
      dwd = 16'($urandom);
      run_case(si, ia, sd, dw, da, dwd, idc, ddc, en_cnt, fw, fa, fd, viol);
      model_case(si, ia, sd, dw, da, dwd, e_idc, e_ddc, e_en, e_fw, e_fa, e_fd);
      chk($sformatf("rnd%0d i_done_cycle", t), idc, e_idc);
      chk($sformatf("rnd%0d d_done_cycle", t), ddc, e_ddc);
      chk($sformatf("rnd%0d i_rdata", t), int'(i_rdata), int'(m_last_i));
      chk($sformatf("rnd%0d d_rdata", t), int'(d_rdata), int'(m_last_d));
      chk($sformatf("rnd%0d mem_enable_count", t), en_cnt, e_en);
      chk($sformatf("rnd%0d first_access", t), {15'd0, fw, fa, 16'd0} == {15'd0, e_fw, e_fa, 16'd0} && fd == e_fd ? 1 : 0, 1);
      chk($sformatf("rnd%0d done_protocol", t), viol, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
